// File: rtl/gemm_stream_driver.sv
// Valid/ready streaming wrapper around the 2x2 32-bit pipelined GEMM core.
// Optional job counter enabled by defining GEMM_STREAM_JOBCNT_EN.
module gemm_stream_driver #(
   parameter int unsigned GEMM_LATENCY = 6,
   parameter int unsigned CNT_W        = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [31:0]        s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [31:0]        m_data,
   output logic               m_last,
   output logic [127:0]       gemm_A,
   output logic [127:0]       gemm_B,
   input  logic [127:0]       gemm_out,
   output logic               busy,
   output logic [CNT_W-1:0]   job_count
);

   localparam int unsigned EW     = 32;
   localparam int unsigned MW     = 128;
   localparam int unsigned WAIT_W = (GEMM_LATENCY < 1) ? 1 : $clog2(GEMM_LATENCY + 1);

   typedef enum logic [1:0] {ST_LOAD, ST_WAIT, ST_DRAIN} state_e;

   state_e              state_q, state_d;
   logic [2:0]          idx_q, idx_d;
   logic [1:0]          ridx_q, ridx_d;
   logic [WAIT_W-1:0]   wcnt_q, wcnt_d;
   logic [MW-1:0]       a_q, a_d, b_q, b_d, res_q, res_d;
   logic                s_ready_q, s_ready_d;
   logic                m_valid_q, m_valid_d;
   logic                m_last_q, m_last_d;
   logic                busy_q, busy_d;
   logic [EW-1:0]       m_data_q, m_data_d;

   // Next state plus output flags decoded from the next state so every output is a flop.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      ridx_d  = ridx_q;
      wcnt_d  = wcnt_q;
      a_d     = a_q;
      b_d     = b_q;
      res_d   = res_q;
      case (state_q)
         ST_LOAD: begin
            if (s_valid && s_ready_q) begin
               if (idx_q[2]) b_d[{idx_q[1:0], 5'd0} +: EW] = s_data;
               else          a_d[{idx_q[1:0], 5'd0} +: EW] = s_data;
               idx_d = idx_q + 3'd1;
               if (idx_q == 3'd7) begin
                  wcnt_d  = WAIT_W'(GEMM_LATENCY);
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wcnt_q == '0) begin
               res_d   = gemm_out;
               ridx_d  = 2'd0;
               state_d = ST_DRAIN;
            end else begin
               wcnt_d = wcnt_q - WAIT_W'(1);
            end
         end
         ST_DRAIN: begin
            if (m_ready && m_valid_q) begin
               ridx_d = ridx_q + 2'd1;
               if (ridx_q == 2'd3) state_d = ST_LOAD;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      s_ready_d = (state_d == ST_LOAD);
      m_valid_d = (state_d == ST_DRAIN);
      busy_d    = (state_d != ST_LOAD);
      m_last_d  = (state_d == ST_DRAIN) && (ridx_d == 2'd3);
      m_data_d  = (state_d == ST_DRAIN) ? res_d[{ridx_d, 5'd0} +: EW] : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_LOAD;
         idx_q     <= '0;
         ridx_q    <= '0;
         wcnt_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         s_ready_q <= 1'b1;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         busy_q    <= 1'b0;
         m_data_q  <= '0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         ridx_q    <= ridx_d;
         wcnt_q    <= wcnt_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         s_ready_q <= s_ready_d;
         m_valid_q <= m_valid_d;
         m_last_q  <= m_last_d;
         busy_q    <= busy_d;
         m_data_q  <= m_data_d;
      end
   end

   assign s_ready = s_ready_q;
   assign m_valid = m_valid_q;
   assign m_last  = m_last_q;
   assign m_data  = m_data_q;
   assign busy    = busy_q;
   assign gemm_A  = a_q;
   assign gemm_B  = b_q;

`ifdef GEMM_STREAM_JOBCNT_EN
   logic [CNT_W-1:0] jobs_q, jobs_d;

   // A job completes on the handshake of the last result element.
   always_comb begin
      jobs_d = jobs_q;
      if (state_q == ST_DRAIN && m_valid_q && m_ready && ridx_q == 2'd3)
         jobs_d = jobs_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) jobs_q <= '0;
      else     jobs_q <= jobs_d;
   end

   assign job_count = jobs_q;
`else
   assign job_count = '0;
`endif

endmodule

// File: tb/tb_gemm_stream_driver.sv
// Self-checking bench for gemm_stream_driver with a behavioural pipelined GEMM core.
module tb_gemm_stream_driver;

   localparam int unsigned LAT = 6;
   localparam int unsigned CW  = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          s_valid, s_ready;
   logic [31:0]   s_data;
   logic          m_valid, m_ready;
   logic [31:0]   m_data;
   logic          m_last;
   logic [127:0]  gemm_A, gemm_B, gemm_out;
   logic          busy;
   logic [CW-1:0] job_count;

   int total = 0;
   int bad   = 0;
   int jobs_exp = 0;

   gemm_stream_driver #(.GEMM_LATENCY(LAT), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .gemm_A(gemm_A), .gemm_B(gemm_B), .gemm_out(gemm_out),
      .busy(busy), .job_count(job_count)
   );

   always #5 clk = ~clk;

   // Stand-in for the GEMM core: LAT register stages from operands to out.
   function automatic logic [127:0] core_mul(input logic [127:0] a, input logic [127:0] b);
      logic [31:0] x [4];
      logic [31:0] y [4];
      for (int i = 0; i < 4; i++) begin
         x[i] = a[32*i +: 32];
         y[i] = b[32*i +: 32];
      end
      return {x[2]*y[1] + x[3]*y[3], x[2]*y[0] + x[3]*y[2],
              x[0]*y[1] + x[1]*y[3], x[0]*y[0] + x[1]*y[2]};
   endfunction

   logic [127:0] pipe [LAT];
   always_ff @(posedge clk) begin
      pipe[0] <= core_mul(gemm_A, gemm_B);
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign gemm_out = pipe[LAT-1];

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference product from 2-D matrices, row-major element lists in and out.
   task automatic ref_c(input int unsigned a[4], input int unsigned b[4], output int unsigned c[4]);
      int unsigned am [2][2];
      int unsigned bm [2][2];
      for (int r = 0; r < 2; r++)
         for (int k = 0; k < 2; k++) begin
            am[r][k] = a[2*r+k];
            bm[r][k] = b[2*r+k];
         end
      for (int r = 0; r < 2; r++)
         for (int col = 0; col < 2; col++) begin
            int unsigned acc = 0;
            for (int k = 0; k < 2; k++) acc += am[r][k] * bm[k][col];
            c[2*r+col] = acc;
         end
   endtask

   task automatic send_beat(input int unsigned d, input bit bubbles);
      if (bubbles) begin
         int k = $urandom_range(0, 2);
         repeat (k) begin
            s_valid = 1'b0;
            s_data  = $urandom;
            @(posedge clk); #1;
         end
      end
      chk("s_ready_load", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = d;
      @(posedge clk); #1;
      s_valid = 1'b0;
   endtask

   task automatic send_beats(input int unsigned a[4], input int unsigned b[4], input int n, input bit bubbles);
      for (int i = 0; i < n; i++)
         send_beat((i < 4) ? a[i] : b[i-4], bubbles);
   endtask

   task automatic load_job(input int unsigned a[4], input int unsigned b[4], input bit bubbles);
      send_beats(a, b, 8, bubbles);
      chk("gemm_A_pack", gemm_A, {a[3], a[2], a[1], a[0]});
      chk("gemm_B_pack", gemm_B, {b[3], b[2], b[1], b[0]});
      chk("busy_wait", busy, 1'b1);
      chk("s_ready_wait", s_ready, 1'b0);
   endtask

   // Counts cycles from the last input handshake to m_valid; s_valid noise must be ignored.
   task automatic wait_result(input int unsigned a[4], input int unsigned b[4]);
      int n = 0;
      while (!m_valid && n < 50) begin
         chk("s_ready_wait_loop", s_ready, 1'b0);
         s_valid = 1'($urandom_range(0, 1));
         s_data  = $urandom;
         @(posedge clk); #1;
         n++;
      end
      s_valid = 1'b0;
      chk("latency", 128'(n), 128'(LAT + 1));
      chk("gemm_A_hold", gemm_A, {a[3], a[2], a[1], a[0]});
      chk("gemm_B_hold", gemm_B, {b[3], b[2], b[1], b[0]});
   endtask

   task automatic drain(input int unsigned c[4], input int nbeats, input int stall_at, input int stall_len);
      for (int r = 0; r < nbeats; r++) begin
         if (r == stall_at) begin
            logic [31:0] hold;
            m_ready = 1'b0;
            hold = m_data;
            repeat (stall_len) begin
               @(posedge clk); #1;
               chk("stall_valid", m_valid, 1'b1);
               chk("stall_hold", m_data, hold);
               chk("stall_s_ready", s_ready, 1'b0);
            end
         end
         m_ready = 1'b1;
         chk("m_valid", m_valid, 1'b1);
         chk("m_data", m_data, c[r]);
         chk("m_last", m_last, (r == 3));
         chk("s_ready_drain", s_ready, 1'b0);
         @(posedge clk); #1;
         if (r == 3) jobs_exp++;
      end
      if (nbeats == 4) begin
         chk("m_valid_done", m_valid, 1'b0);
         chk("s_ready_done", s_ready, 1'b1);
         chk("busy_done", busy, 1'b0);
`ifdef GEMM_STREAM_JOBCNT_EN
         chk("job_count", job_count, jobs_exp);
`else
         chk("job_count", job_count, 0);
`endif
      end
   endtask

   task automatic run_job(input int unsigned a[4], input int unsigned b[4], input bit bubbles,
                          input int stall_at, input int stall_len);
      int unsigned c [4];
      ref_c(a, b, c);
      load_job(a, b, bubbles);
      wait_result(a, b);
      drain(c, 4, stall_at, stall_len);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      jobs_exp = 0;
      chk("rst_gemm_A", gemm_A, 0);
      chk("rst_gemm_B", gemm_B, 0);
      chk("rst_s_ready", s_ready, 1'b1);
      chk("rst_m_valid", m_valid, 1'b0);
      chk("rst_m_data", m_data, 0);
      chk("rst_m_last", m_last, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_job_count", job_count, 0);
   endtask

   initial begin
      int unsigned a [4];
      int unsigned b [4];
      int unsigned c [4];
      rst = 1'b1; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      pulse_reset();

      a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
      ref_c(a, b, c);
      chk("ref_basic", {c[3], c[2], c[1], c[0]}, {32'd50, 32'd43, 32'd22, 32'd19});
      m_ready = 1'b1;
      run_job(a, b, 1'b0, -1, 0);

      a = '{32'hFFFF_FFFF, 0, 0, 1}; b = '{2, 0, 0, 1};
      ref_c(a, b, c);
      chk("ref_wrap", {c[3], c[2], c[1], c[0]}, {32'd1, 32'd0, 32'd0, 32'hFFFF_FFFE});
      run_job(a, b, 1'b0, -1, 0);

      a = '{1, 2, 3, 4}; b = '{5, 6, 7, 8};
      run_job(a, b, 1'b1, 2, 5);

      // Reset after five beats discards the partial operands.
      send_beats(a, b, 5, 1'b0);
      pulse_reset();
      run_job(a, b, 1'b0, -1, 0);

      // Reset during drain loses the remaining results.
      ref_c(a, b, c);
      load_job(a, b, 1'b0);
      wait_result(a, b);
      drain(c, 2, -1, 0);
      pulse_reset();
      repeat (3) begin
         @(posedge clk); #1;
         chk("abort_no_valid", m_valid, 1'b0);
      end

      b = '{1, 0, 0, 1};
      a = '{1, 2, 3, 4};     run_job(a, b, 1'b0, -1, 0);
      a = '{5, 6, 7, 8};     run_job(a, b, 1'b0, -1, 0);
      a = '{9, 10, 11, 12};  run_job(a, b, 1'b0, -1, 0);
`ifdef GEMM_STREAM_JOBCNT_EN
      chk("job_count_three", job_count, 3);
`else
      chk("job_count_three", job_count, 0);
`endif

      for (int j = 0; j < 4; j++) begin
         for (int i = 0; i < 4; i++) begin
            a[i] = $urandom;
            b[i] = $urandom;
         end
         run_job(a, b, 1'b1, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
